ps2_key_scan: RTL and testbench

//  PS/2 keyboard receiver feeding the data RAM's key-injection port. Samples ps2_clk/ps2_data,

---
 rtl/ps2_key_scan.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_key_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_scan.sv
// PS/2 scan-code set 2 receiver that presents the held key as ASCII on the RAM key-injection port.
// Optional SHIFT_CASE_EN: shift-aware letter case and shifted digit symbols.
module ps2_key_scan #(
  parameter logic [12:0] KEY_ADDR    = 13'h0310,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [12:0] key_ram_addr,
  output logic [31:0] key_ram_wdata,
  output logic        key_ram_wen,
  output logic [7:0]  scan_code
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic { F_IDLE, F_RECV } frame_t;
  typedef enum logic [1:0] { D_NORM, D_BRK, D_EXT, D_EXT_BRK } dec_t;

  logic [2:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  frame_t          r_fstate, w_fstate_nxt;
  dec_t            r_dstate, w_dstate_nxt;
  logic [3:0]      r_bit_cnt;
  logic [8:0]      r_shift;
  logic [WD_W-1:0] r_wdog;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic [7:0]      r_ascii;
  logic [7:0]      r_held;
  logic            r_wen;
  logic [7:0]      r_scan;
  logic            w_fall, w_dat, w_frame_ok, w_wdog_exp;
  logic            w_make, w_brk, w_mapped, w_repeat;
  logic [7:0]      w_base, w_ascii;

  // Extra stage on the clock sync gives the previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_dat      = r_dat_sync[1];
  assign w_wdog_exp = (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fstate <= F_IDLE;
    else     r_fstate <= w_fstate_nxt;
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    w_frame_ok   = 1'b0;
    case (r_fstate)
      F_IDLE: if (w_fall && !w_dat) w_fstate_nxt = F_RECV;
      F_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) begin
            w_fstate_nxt = F_IDLE;
            w_frame_ok   = (^r_shift) & w_dat;
          end
        end else if (w_wdog_exp) begin
          w_fstate_nxt = F_IDLE;
        end
      end
      default: w_fstate_nxt = F_IDLE;
    endcase
  end

  // Data bits and parity shift in LSB first; the stop bit is checked live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= 9'd0;
      r_wdog     <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= 8'd0;
    end else begin
      r_byte_vld <= w_frame_ok;
      if (w_frame_ok) r_byte <= r_shift[7:0];
      if (r_fstate == F_IDLE) begin
        r_bit_cnt <= 4'd0;
        r_wdog    <= '0;
      end else if (w_fall) begin
        r_wdog    <= '0;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_bit_cnt < 4'd9) r_shift <= {w_dat, r_shift[8:1]};
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dstate <= D_NORM;
    else     r_dstate <= w_dstate_nxt;
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    if (r_byte_vld) begin
      case (r_dstate)
        D_NORM: begin
          if (r_byte == 8'hF0)      w_dstate_nxt = D_BRK;
          else if (r_byte == 8'hE0) w_dstate_nxt = D_EXT;
          else if (r_byte != 8'hE1 && r_byte != 8'hAA && r_byte != 8'hFA) w_make = 1'b1;
        end
        D_BRK: begin
          w_brk        = 1'b1;
          w_dstate_nxt = D_NORM;
        end
        D_EXT:     w_dstate_nxt = (r_byte == 8'hF0) ? D_EXT_BRK : D_NORM;
        D_EXT_BRK: w_dstate_nxt = D_NORM;
        default:   w_dstate_nxt = D_NORM;
      endcase
    end
  end

  // Unshifted set-2 map; zero means unmapped.
  function automatic logic [7:0] ascii_base(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;  8'h23: return 8'h44;
      8'h24: return 8'h45;  8'h2B: return 8'h46;  8'h34: return 8'h47;  8'h33: return 8'h48;
      8'h43: return 8'h49;  8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;  8'h4D: return 8'h50;
      8'h15: return 8'h51;  8'h2D: return 8'h52;  8'h1B: return 8'h53;  8'h2C: return 8'h54;
      8'h3C: return 8'h55;  8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
      8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;  8'h3D: return 8'h37;
      8'h3E: return 8'h38;  8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  assign w_base = ascii_base(r_byte);

`ifdef SHIFT_CASE_EN
  logic r_shift_l, r_shift_r, w_shift_held;
  assign w_shift_held = r_shift_l | r_shift_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
    end else if (w_make || w_brk) begin
      if (r_byte == 8'h12) r_shift_l <= w_make;
      if (r_byte == 8'h59) r_shift_r <= w_make;
    end
  end

  always_comb begin
    w_ascii = w_base;
    if (w_base >= 8'h41 && w_base <= 8'h5A) begin
      if (!w_shift_held) w_ascii = w_base + 8'h20;
    end else if (w_shift_held) begin
      case (w_base)
        8'h30: w_ascii = 8'h29;  8'h31: w_ascii = 8'h21;  8'h32: w_ascii = 8'h40;
        8'h33: w_ascii = 8'h23;  8'h34: w_ascii = 8'h24;  8'h35: w_ascii = 8'h25;
        8'h36: w_ascii = 8'h5E;  8'h37: w_ascii = 8'h26;  8'h38: w_ascii = 8'h2A;
        8'h39: w_ascii = 8'h28;
        default: w_ascii = w_base;
      endcase
    end
  end
`else
  assign w_ascii = w_base;
`endif

  assign w_mapped = (w_ascii != 8'h00);
  assign w_repeat = r_wen && (r_byte == r_held);

  // A repeat make must not relatch, so a held key keeps the case it was pressed with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ascii <= 8'd0;
      r_held  <= 8'd0;
      r_wen   <= 1'b0;
      r_scan  <= 8'd0;
    end else begin
      if (r_byte_vld) r_scan <= r_byte;
      if (w_make && w_mapped && !w_repeat) begin
        r_ascii <= w_ascii;
        r_held  <= r_byte;
        r_wen   <= 1'b1;
      end else if (w_brk && w_repeat) begin
        r_ascii <= 8'd0;
        r_wen   <= 1'b0;
      end
    end
  end

  assign key_ram_addr  = KEY_ADDR;
  assign key_ram_wdata = {24'h0, r_ascii};
  assign key_ram_wen   = r_wen;
  assign scan_code     = r_scan;

endmodule

// File: tb/tb_ps2_key_scan.sv
// Randomized PS/2 frame stimulus against a byte-level keyboard model; latency checked on every frame.
module tb_ps2_key_scan;
  localparam int TO   = 2000;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data;
  logic [12:0] key_ram_addr;
  logic [31:0] key_ram_wdata;
  logic        key_ram_wen;
  logic [7:0]  scan_code;

  ps2_key_scan #(.KEY_ADDR(13'h0310), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_ram_addr(key_ram_addr), .key_ram_wdata(key_ram_wdata),
    .key_ram_wen(key_ram_wen), .scan_code(scan_code)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Keyboard model: what a user holding keys should see on the port.
  string      letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  string      sym     = ")!@#$%^&*(";
  logic [7:0] lcodes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                              8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                              8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dcodes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] misc [3] = '{8'h29, 8'h5A, 8'h66};
  logic [7:0] oth  [6] = '{8'h12, 8'h59, 8'hE1, 8'hAA, 8'hFA, 8'h75};

  bit         m_brk, m_ext, m_held, m_sl, m_sr;
  logic [7:0] m_code, m_ascii, m_scan;

  task automatic m_reset();
    m_brk = 0; m_ext = 0; m_held = 0; m_sl = 0; m_sr = 0;
    m_code = 8'h00; m_ascii = 8'h00; m_scan = 8'h00;
  endtask

  function automatic logic [7:0] m_lookup(input logic [7:0] c);
    logic [7:0] ch;
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (lcodes[i] == c) begin
        ch = letters[i];
`ifdef SHIFT_CASE_EN
        if (!(m_sl || m_sr)) ch = ch + 8'd32;
`endif
      end
    for (int i = 0; i < 10; i++)
      if (dcodes[i] == c) begin
        ch = 8'h30 + 8'(i);
`ifdef SHIFT_CASE_EN
        if (m_sl || m_sr) ch = sym[i];
`endif
      end
    if (c == 8'h29) ch = 8'h20;
    if (c == 8'h5A) ch = 8'h0D;
    if (c == 8'h66) ch = 8'h08;
    return ch;
  endfunction

  task automatic m_press(input logic [7:0] b);
    logic [7:0] a;
`ifdef SHIFT_CASE_EN
    if (b == 8'h12) m_sl = 1;
    if (b == 8'h59) m_sr = 1;
`endif
    a = m_lookup(b);
    if (a != 8'h00 && !(m_held && b == m_code)) begin
      m_ascii = a; m_held = 1; m_code = b;
    end
  endtask

  task automatic m_release(input logic [7:0] b);
`ifdef SHIFT_CASE_EN
    if (b == 8'h12) m_sl = 0;
    if (b == 8'h59) m_sr = 0;
`endif
    if (m_held && b == m_code) begin
      m_held = 0; m_ascii = 8'h00;
    end
  endtask

  task automatic m_apply(input logic [7:0] b);
    m_scan = b;
    if (m_ext) begin
      if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      m_release(b);
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b != 8'hE1 && b != 8'hAA && b != 8'hFA) m_press(b);
  endtask

  // One 11-bit frame; output must hold old value 3 clks after the stop fall and change at the 4th.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int gap_bit, input int gap_len);
    logic [10:0] bits;
    logic [31:0] o_w, o_s;
    bit          o_e;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    o_w = {24'h0, m_ascii}; o_e = m_held; o_s = {24'h0, m_scan};
    if (!bad_par && !bad_stop) m_apply(b);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) ps2_data = bits[i];
      if (i == gap_bit) repeat (gap_len) @(negedge clk);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(posedge clk);
        #1;
        check("wdata_pre", key_ram_wdata, o_w);
        check("wen_pre", {31'h0, key_ram_wen}, {31'h0, o_e});
        check("scan_pre", {24'h0, scan_code}, o_s);
        @(posedge clk);
        #1;
        check("wdata_post", key_ram_wdata, {24'h0, m_ascii});
        check("wen_post", {31'h0, key_ram_wen}, {31'h0, m_held});
        check("scan_post", {24'h0, scan_code}, {24'h0, m_scan});
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1, 0);
  endtask

  function automatic logic [7:0] pick();
    int c;
    c = $urandom_range(0, 9);
    if (c < 4)       return lcodes[$urandom_range(0, 25)];
    else if (c < 6)  return dcodes[$urandom_range(0, 9)];
    else if (c == 6) return misc[$urandom_range(0, 2)];
    else if (c == 7) return ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hE0;
    else if (c == 8) return oth[$urandom_range(0, 5)];
    else             return 8'($urandom_range(0, 255));
  endfunction

  int r;
  bit bp, bs;

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_reset();
    repeat (5) @(negedge clk);
    check("rst_wen", {31'h0, key_ram_wen}, 32'h0);
    check("rst_wdata", key_ram_wdata, 32'h0);
    check("rst_scan", {24'h0, scan_code}, 32'h0);
    check("rst_addr", {19'h0, key_ram_addr}, 32'h0310);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame while a key is held
    good(8'h1C);
    send_partial(4);
    @(negedge clk) rst = 1'b1;
    #1;
    m_reset();
    check("midrst_wen", {31'h0, key_ram_wen}, 32'h0);
    check("midrst_wdata", key_ram_wdata, 32'h0);
    check("midrst_scan", {24'h0, scan_code}, 32'h0);
    check("midrst_addr", {19'h0, key_ram_addr}, 32'h0310);
    repeat (3) @(negedge clk) rst = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Make / break
    good(8'h1C);
`ifdef SHIFT_CASE_EN
    check("t2_make", key_ram_wdata, 32'h61);
`else
    check("t2_make", key_ram_wdata, 32'h41);
`endif
    good(8'hF0); good(8'h1C);
    check("t2_brk", key_ram_wdata, 32'h0);

    // Bad parity, bad stop, timeout
    send_frame(8'h1C, 1'b1, 1'b0, -1, 0);
    send_frame(8'h32, 1'b0, 1'b1, -1, 0);
    send_partial(7);
    repeat (TO + 20) @(negedge clk);
    good(8'h16);
    check("t3_to", key_ram_wdata, 32'h31);
    good(8'hF0); good(8'h16);

    // Mid-frame gap just short of the timeout must not drop the frame
    send_frame(8'h45, 1'b0, 1'b0, 5, TO - 2 * HALF - 50);
    check("gap_ok", key_ram_wdata, 32'h30);
    good(8'hF0); good(8'h45);

    // Rollover
    good(8'h1C); good(8'h32); good(8'hF0); good(8'h1C);
    check("t4_roll_wen", {31'h0, key_ram_wen}, 32'h1);
    good(8'hF0); good(8'h32);
    check("t4_rel_wen", {31'h0, key_ram_wen}, 32'h0);

    // Extended prefixes are ignored
    good(8'hE0); good(8'h75); good(8'hE0); good(8'hF0); good(8'h75);
    check("t5_ext", {31'h0, key_ram_wen}, 32'h0);
    good(8'h29);
    check("t5_space", key_ram_wdata, 32'h20);
    good(8'hF0); good(8'h29);

    // Shift handling
    good(8'h12); good(8'h1C);
    check("t6_shift", key_ram_wdata, 32'h41);
    good(8'hF0); good(8'h1C); good(8'hF0); good(8'h12); good(8'h1C);
`ifdef SHIFT_CASE_EN
    check("t6_noshift", key_ram_wdata, 32'h61);
`else
    check("t6_noshift", key_ram_wdata, 32'h41);
`endif
    good(8'hF0); good(8'h1C);

    // Stray fall with data high in idle is not a start bit
    @(negedge clk) ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    good(8'h32);

    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 99);
      bp = ($urandom_range(0, 19) == 0);
      bs = !bp && ($urandom_range(0, 24) == 0);
      if (r < 20 && m_held) begin
        good(8'hF0);
        send_frame(m_code, bp, bs, -1, 0);
      end else begin
        send_frame(pick(), bp, bs, -1, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
